// File: rtl/core_dispatcher.sv
// ============================================================================
// Module   : core_dispatcher
// Brief    : Run-control sequencer for one matrix-multiplication job across a
//            set of compute cores: memory wait, release, completion collection,
//            watchdog. Optional macro CORE_DISPATCHER_PERF_EN exposes run_cycles
//            and adds the first_done_cycles port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_dispatcher #(
    parameter int N_CORES    = 4,
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 16'hFFFF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N_CORES-1:0]      core_mask,
    input  logic                    mem_ready,
    input  logic                    ack,
    input  logic [N_CORES-1:0]      end_process,
    output logic [2*N_CORES-1:0]    status,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [N_CORES-1:0]      done_vec,
    output logic [WDOG_W-1:0]       run_cycles
`ifdef CORE_DISPATCHER_PERF_EN
    ,
    output logic [WDOG_W-1:0]       first_done_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_MEM = 3'd1,
        S_RUN      = 3'd2,
        S_DONE     = 3'd3,
        S_TIMEOUT  = 3'd4
    } state_t;

    localparam logic [1:0]        C_HOLD      = 2'b00;
    localparam logic [1:0]        C_RUN       = 2'b01;
    localparam logic [1:0]        C_FACK      = 2'b10;
    localparam logic [WDOG_W-1:0] C_WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);
    localparam logic [WDOG_W-1:0] C_WDOG_MAX  = '1;

    state_t                 state_q, state_d;
    logic [N_CORES-1:0]     mask_q, mask_d;
    logic [N_CORES-1:0]     done_vec_q, done_vec_d;
    logic [WDOG_W-1:0]      wdog_q, wdog_d;
    logic [2*N_CORES-1:0]   status_q, status_d;
    logic                   busy_q, done_q, timeout_q;
    logic [WDOG_W-1:0]      first_q, first_d;

    logic [N_CORES-1:0]     w_ep_hits;
    logic                   w_done_all;

    // Completion in the current cycle counts, so end_process is OR-ed in directly.
    assign w_ep_hits  = end_process & mask_q;
    assign w_done_all = &(done_vec_q | end_process | ~mask_q);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        done_vec_d = done_vec_q;
        wdog_d     = wdog_q;
        first_d    = first_q;
        status_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d     = core_mask;
                    done_vec_d = '0;
                    wdog_d     = '0;
                    first_d    = '0;
                    state_d    = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                if (mask_q == '0) begin
                    state_d = S_DONE;
                end else if (mem_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                done_vec_d = done_vec_q | w_ep_hits;
                if (wdog_q != C_WDOG_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end
                if ((done_vec_q == '0) && (w_ep_hits != '0)) begin
                    first_d = wdog_q;
                end
                // Completion takes priority over an expiring watchdog.
                if (w_done_all) begin
                    state_d = S_DONE;
                end else if (wdog_q == C_WDOG_LAST) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_DONE, S_TIMEOUT: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status lags the state/done_vec that selects it by one cycle.
        for (int i = 0; i < N_CORES; i++) begin
            status_d[2*i +: 2] = C_HOLD;
            if (mask_q[i]) begin
                if (state_q == S_RUN) begin
                    status_d[2*i +: 2] = done_vec_q[i] ? C_FACK : C_RUN;
                end else if (state_q == S_DONE) begin
                    status_d[2*i +: 2] = C_FACK;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            done_vec_q <= '0;
            wdog_q     <= '0;
            first_q    <= '0;
            status_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            done_vec_q <= done_vec_d;
            wdog_q     <= wdog_d;
            first_q    <= first_d;
            status_q   <= status_d;
            busy_q     <= (state_d == S_WAIT_MEM) || (state_d == S_RUN);
            done_q     <= (state_d == S_DONE);
            timeout_q  <= (state_d == S_TIMEOUT);
        end
    end

    assign status   = status_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign done_vec = done_vec_q;

`ifdef CORE_DISPATCHER_PERF_EN
    assign run_cycles        = wdog_q;
    assign first_done_cycles = first_q;
`else
    // The watchdog counter keeps running internally; only its export is gated.
    assign run_cycles = '0;
    logic w_unused_first;
    assign w_unused_first = ^first_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_dispatcher.sv
// ============================================================================
// Module   : tb_core_dispatcher
// Brief    : Directed scoreboard bench for core_dispatcher (WDOG_LIMIT = 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_dispatcher;

    localparam int N_CORES    = 4;
    localparam int WDOG_W     = 16;
    localparam int WDOG_LIMIT = 16;
`ifdef CORE_DISPATCHER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic [N_CORES-1:0]    core_mask;
    logic                  mem_ready;
    logic                  ack;
    logic [N_CORES-1:0]    end_process;
    logic [2*N_CORES-1:0]  status;
    logic                  busy;
    logic                  done;
    logic                  timeout;
    logic [N_CORES-1:0]    done_vec;
    logic [WDOG_W-1:0]     run_cycles;
`ifdef CORE_DISPATCHER_PERF_EN
    logic [WDOG_W-1:0]     first_done_cycles;
`endif

    core_dispatcher #(
        .N_CORES    (N_CORES),
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .core_mask   (core_mask),
        .mem_ready   (mem_ready),
        .ack         (ack),
        .end_process (end_process),
        .status      (status),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .done_vec    (done_vec),
        .run_cycles  (run_cycles)
`ifdef CORE_DISPATCHER_PERF_EN
        ,
        .first_done_cycles (first_done_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow: observed %0h with nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic finish_job();
        end_process = '0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        core_mask   = '0;
        mem_ready   = 1'b0;
        ack         = 1'b0;
        end_process = '0;
        tick();
        tick();

        // Reset state
        push("rst_status", 0);   check(status);
        push("rst_busy", 0);     check(busy);
        push("rst_done", 0);     check(done);
        push("rst_timeout", 0);  check(timeout);
        push("rst_done_vec", 0); check(done_vec);
        push("rst_run_cycles", 0); check(run_cycles);
        reset = 1'b0;
        tick();

        // Basic job: all cores, memory ready, staggered completion
        core_mask = 4'hF;
        mem_ready = 1'b1;
        start     = 1'b1;
        push("basic_busy", 1);
        tick();
        start = 1'b0;
        check(busy);
        push("basic_status_lag", 8'h00);
        tick();
        check(status);
        push("basic_status_run", 8'h55);
        tick();
        check(status);
        push("basic_mid_done_vec", 4'h3);
        push("basic_done", 1);
        push("basic_done_vec", 4'hF);
        push("basic_run_cycles", PERF ? 10 : 0);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            end_process[0] = (cyc >= 5);
            end_process[1] = (cyc >= 7);
            end_process[2] = (cyc >= 9);
            end_process[3] = (cyc >= 9);
            if (cyc == 8) check(done_vec);
            tick();
        end
        check(done);
        check(done_vec);
        check(run_cycles);
`ifdef CORE_DISPATCHER_PERF_EN
        push("basic_first_done", 5); check(first_done_cycles);
`endif
        push("basic_status_fack", 8'hAA);
        tick();
        check(status);
        finish_job();
        push("basic_idle_done", 0); check(done);
        push("basic_idle_busy", 0); check(busy);

        // Partial mask: unmasked completions ignored
        core_mask = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        end_process = 4'b1010;
        push("part_done_vec", 0);
        push("part_busy", 1);
        push("part_status", 8'h11);
        tick(); tick(); tick();
        check(done_vec);
        check(busy);
        check(status);
        end_process = 4'b0101;
        push("part_done", 1);
        push("part_done_vec_final", 4'h5);
        tick();
        check(done);
        check(done_vec);
        push("part_status_fack", 8'h22);
        tick();
        check(status);
        finish_job();

        // Memory wait
        core_mask = 4'hF;
        mem_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push("memwait_status", 0); check(status);
            push("memwait_busy", 1);   check(busy);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        push("memwait_status_lag", 0); check(status);
        tick();
        push("memwait_status_run", 8'h55); check(status);
        end_process = 4'hF;
        tick();
        push("memwait_done", 1); check(done);
        finish_job();

        // Watchdog: only core 0 finishes, from RUN cycle 3
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int cyc = 0; cyc < 15; cyc++) begin
            end_process[0] = (cyc >= 3);
            tick();
        end
        push("wdog_busy_c15", 1);    check(busy);
        push("wdog_timeout_c15", 0); check(timeout);
        tick();
        push("wdog_timeout", 1);   check(timeout);
        push("wdog_busy_to", 0);   check(busy);
        push("wdog_done_to", 0);   check(done);
        push("wdog_run_cycles", PERF ? 16 : 0); check(run_cycles);
        push("wdog_done_vec", 4'h1); check(done_vec);
`ifdef CORE_DISPATCHER_PERF_EN
        push("wdog_first_done", 3); check(first_done_cycles);
`endif
        end_process = 4'hF;
        tick();
        push("wdog_done_vec_frozen", 4'h1); check(done_vec);
        push("wdog_status_hold", 0);        check(status);
        finish_job();
        push("wdog_ack_timeout", 0); check(timeout);
        push("wdog_ack_busy", 0);    check(busy);

        // Completion exactly on the last watchdog cycle wins over timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int cyc = 0; cyc < 15; cyc++) tick();
        end_process = 4'hF;
        tick();
        push("race_done", 1);    check(done);
        push("race_timeout", 0); check(timeout);
        push("race_run_cycles", PERF ? 16 : 0); check(run_cycles);
        finish_job();

        // Empty mask goes straight to DONE
        core_mask = 4'h0;
        mem_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        push("mask0_done", 1);       check(done);
        push("mask0_run_cycles", 0); check(run_cycles);
        // start while in DONE must not relatch the mask or restart
        core_mask = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        push("done_start_done", 1);   check(done);
        push("done_start_busy", 0);   check(busy);
        push("done_start_status", 0); check(status);
        finish_job();

        // Asynchronous reset in the middle of RUN
        mem_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        push("rstrun_status_pre", 8'h55); check(status);
        #2;
        reset = 1'b1;
        #1;
        push("rstrun_status_async", 0); check(status);
        push("rstrun_busy_async", 0);   check(busy);
        @(negedge clock);
        reset = 1'b0;
        tick();
        push("rstrun_busy", 0);     check(busy);
        push("rstrun_done", 0);     check(done);
        push("rstrun_done_vec", 0); check(done_vec);
        push("rstrun_status", 0);   check(status);

        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
